shift_cmd_queue: RTL

- Upstream command stage for the 8-bit barrel shifter.
- Accepts (data, shift amount) pairs over a valid/ready handshake and buffers them in a small FIFO.
- Issues one pair at a time on x/shift_n and holds each for a fixed number of clk cycles, so the registered shifter output settles before the next command.
- Replaces hand-timed stimulus with a paced, back-pressured command stream.

---
 rtl/shift_cmd_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shift_cmd_queue.sv
// shift_cmd_queue: valid/ready command FIFO that paces (data, shift) pairs
// into the barrel shifter, presenting each one for HOLD_CYC clock cycles.
// Optional build macro SHIFT_CMD_WRAP_EN: reduce the issued shift amount
// modulo DATA_W; without it the raw shift amount is passed through.
module shift_cmd_queue #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned SH_W     = 4,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SH_W-1:0]          in_shift,
  output logic [DATA_W-1:0]        x,
  output logic [SH_W-1:0]          shift_n,
  output logic                     issue,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem_data  [DEPTH];
  logic [SH_W-1:0]     r_mem_shift [DEPTH];
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW-1:0]       r_level;
  logic [CW-1:0]       r_hold_cnt;
  logic [DATA_W-1:0]   r_x;
  logic [SH_W-1:0]     r_shift_n;
  logic                r_issue;
  logic                r_busy;

  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic [SH_W-1:0]     w_raw_shift;
  logic [SH_W-1:0]     w_head_shift;

  // Full when the wrap bits differ and the index bits match.
  assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  // A new command may go out from IDLE, or when the current hold window ends.
  assign w_pop = ((r_state == S_IDLE) || (r_hold_cnt == '0)) && (r_level != '0);

  assign w_raw_shift = r_mem_shift[r_rd_ptr[AW-1:0]];

`ifdef SHIFT_CMD_WRAP_EN
  assign w_head_shift = SH_W'(32'(w_raw_shift) % 32'(DATA_W));
`else
  assign w_head_shift = w_raw_shift;
`endif

  assign x       = r_x;
  assign shift_n = r_shift_n;
  assign issue   = r_issue;
  assign busy    = r_busy;
  assign level   = r_level;

  // Storage array; contents are don't-care until covered by the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[AW-1:0]]  <= in_data;
      r_mem_shift[r_wr_ptr[AW-1:0]] <= in_shift;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Issue/hold sequencer with registered shifter-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_x        <= '0;
      r_shift_n  <= '0;
      r_issue    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      if (w_pop) begin
        r_x        <= r_mem_data[r_rd_ptr[AW-1:0]];
        r_shift_n  <= w_head_shift;
        r_issue    <= 1'b1;
        r_busy     <= 1'b1;
        r_hold_cnt <= CW'(HOLD_CYC - 1);
        r_state    <= S_HOLD;
      end else if (r_state == S_HOLD) begin
        if (r_hold_cnt != '0) begin
          r_hold_cnt <= r_hold_cnt - CW'(1);
        end else begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule
